rr_arbiter: RTL and testbench

//  N-requester round-robin arbiter; parametrised successor of the 2-port fixed-priority arbiter.

---
 rtl/rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: NUM_REQ-way round-robin arbiter with registered one-hot grant and owner lock.
// Define ARB_HOLD_LIMIT_EN to cap an owner's tenure at MAX_HOLD cycles when others are waiting.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [IDW-1:0]     gnt_id_reg, gnt_id_next;
  logic [IDW-1:0]     last_id_reg, last_id_next;

  logic [NUM_REQ-1:0] search_req, hi_mask, hi_req, pick, win_oh;
  logic [IDW-1:0]     win_id;
  logic               win_found, owner_req, take;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1) begin : g_bad_param
      $error("rr_arbiter: NUM_REQ must be 2..32 and MAX_HOLD >= 1");
    end
  endgenerate

  // The current owner is removed from the search, so it can only win again after everyone else.
  assign search_req = req & ~gnt_reg;
  assign owner_req  = |(req & gnt_reg);
  assign win_found  = |search_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bits
      assign hi_mask[gi] = (IDW'(gi) > last_id_reg);
      assign win_oh[gi]  = (win_id == IDW'(gi));
    end
  endgenerate

  assign hi_req = search_req & hi_mask;

  // Lowest set bit above last_id wins; otherwise wrap around to the lowest set bit overall.
  always_comb begin
    pick   = (|hi_req) ? hi_req : search_req;
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) win_id = IDW'(i);
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
`endif

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    last_id_next = last_id_reg;
    take         = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_next = hold_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_found) take = 1'b1;
      end
      GRANT: begin
        if (owner_req) begin
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_cnt_reg == HOLD_LAST && win_found) begin
            take = 1'b1;
          end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
`endif
        end else if (win_found) begin
          take = 1'b1;
        end else begin
          state_next = IDLE;
          gnt_next   = '0;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
    if (take) begin
      state_next   = GRANT;
      gnt_next     = win_oh;
      gnt_id_next  = win_id;
      last_id_next = win_id;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_next = '0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      last_id_reg <= IDW'(NUM_REQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      last_id_reg <= last_id_next;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_reg <= hold_cnt_next;
`endif
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = |gnt_reg;
  assign gnt_id    = gnt_id_reg;

`ifndef SYNTHESIS
  req_known_a: assert property (@(posedge clock) disable iff (reset) !$isunknown(req));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a 4-port instance for the main scenarios and a 2-port instance.
`timescale 1ns/1ps
module tb_rr_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [1:0] req2;
  logic [1:0] gnt2;
  logic       gnt_valid2;
  logic       gnt_id2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [3:0] gnt; logic [1:0] id;} exp_t;
  typedef struct packed {logic [1:0] gnt; logic id;} exp2_t;
  exp_t  exp_q[$];
  exp2_t exp2_q[$];

  // Scenario: every owner keeps its grant for two cycles, then drops its request for one.
  logic [3:0] rot_req [10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                               4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
  logic [3:0] rot_gnt [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                               4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
  logic [1:0] rot_id  [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

  rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  rr_arbiter #(.NUM_REQ(2), .MAX_HOLD(8)) dut2 (
    .clock     (clock),
    .reset     (reset),
    .req       (req2),
    .gnt       (gnt2),
    .gnt_valid (gnt_valid2),
    .gnt_id    (gnt_id2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input string tag, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] eid);
    exp_t e;
    req = r;
    exp_q.push_back('{gnt: eg, id: eid});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(|e.gnt));
    check({tag, ".id"}, 32'(gnt_id), 32'(e.id));
    $display("txn %s req=%b gnt=%b valid=%b id=%0d", tag, r, gnt, gnt_valid, gnt_id);
  endtask

  task automatic drive2(input string tag, input logic [1:0] r, input logic [1:0] eg,
                        input logic eid);
    exp2_t e;
    req2 = r;
    exp2_q.push_back('{gnt: eg, id: eid});
    @(posedge clock);
    #1;
    e = exp2_q.pop_front();
    check({tag, ".gnt"}, 32'(gnt2), 32'(e.gnt));
    check({tag, ".valid"}, 32'(gnt_valid2), 32'(|e.gnt));
    check({tag, ".id"}, 32'(gnt_id2), 32'(e.id));
    $display("txn %s req=%b gnt=%b valid=%b id=%0d", tag, r, gnt2, gnt_valid2, gnt_id2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eg;
    reset = 1'b1;
    req   = '0;
    req2  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.valid", 32'(gnt_valid), 32'h0);
    check("rst.id", 32'(gnt_id), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) drive("idle", 4'b0000, 4'b0000, 2'd0);

    for (int i = 0; i < 10; i++) drive("rotate", rot_req[i], rot_gnt[i], rot_id[i]);

    drive("lock", 4'b0100, 4'b0100, 2'd2);
    drive("lock", 4'b0110, 4'b0100, 2'd2);
    drive("lock", 4'b0110, 4'b0100, 2'd2);
    drive("release", 4'b0010, 4'b0010, 2'd1);
    drive("idle_hold_id", 4'b0000, 4'b0000, 2'd1);

    drive("own3", 4'b1000, 4'b1000, 2'd3);
    drive("own3", 4'b1000, 4'b1000, 2'd3);
    #3 reset = 1'b1;
    #1;
    check("async_rst.gnt", 32'(gnt), 32'h0);
    check("async_rst.valid", 32'(gnt_valid), 32'h0);
    check("async_rst.id", 32'(gnt_id), 32'h0);
    req = 4'b1001;
    @(posedge clock);
    #2 reset = 1'b0;
    drive("post_rst", 4'b1001, 4'b0001, 2'd0);
    drive("wrap", 4'b1000, 4'b1000, 2'd3);
    drive("wrap_lock", 4'b1001, 4'b1000, 2'd3);
    drive("wrap_back", 4'b0001, 4'b0001, 2'd0);
    drive("idle2", 4'b0000, 4'b0000, 2'd0);

    for (int n = 0; n < 24; n++) begin
`ifdef ARB_HOLD_LIMIT_EN
      eg = ((n / 8) % 2 == 0) ? 4'b0010 : 4'b0001;
`else
      eg = 4'b0010;
`endif
      drive("hold", 4'b0011, eg, (eg == 4'b0010) ? 2'd1 : 2'd0);
    end
    for (int n = 0; n < 20; n++) drive("solo", 4'b0001, 4'b0001, 2'd0);
    drive("idle3", 4'b0000, 4'b0000, 2'd0);

    reset = 1'b1;
    req2  = 2'b11;
    @(posedge clock);
    #1;
    check("rst2.gnt", 32'(gnt2), 32'h0);
    reset = 1'b0;
    drive2("p2_first", 2'b11, 2'b01, 1'b0);
    drive2("p2_lock", 2'b11, 2'b01, 1'b0);
    drive2("p2_handoff", 2'b10, 2'b10, 1'b1);
    drive2("p2_lock1", 2'b11, 2'b10, 1'b1);
    drive2("p2_back", 2'b01, 2'b01, 1'b0);
    drive2("p2_idle", 2'b00, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
